// File: rtl/alu_sequencer.sv
// Single-issue sequencer in front of the ALU: holds operands/opcode, waits the per-class latency, captures the result.
// Optional build macro: ALU_SEQ_DIV_ZERO_CHECK_EN (short-circuits DIV by zero with an error result).
module alu_sequencer #(
  parameter int TAG_W     = 4,
  parameter int LAT_LOGIC = 1,
  parameter int LAT_ARITH = 4,
  parameter int LAT_MUL   = 66,
  parameter int LAT_DIV   = 130
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [63:0]      i_in_a,
  input  logic [63:0]      i_in_b,
  input  logic [3:0]       i_in_op,
  input  logic [TAG_W-1:0] i_in_tag,
  output logic [63:0]      o_alu_a,
  output logic [63:0]      o_alu_b,
  output logic [3:0]       o_alu_op,
  input  logic [63:0]      i_alu_out,
  input  logic [64:0]      i_alu_rem,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [63:0]      o_res_data,
  output logic [64:0]      o_res_rem,
  output logic             o_res_err,
  output logic [TAG_W-1:0] o_res_tag,
  output logic             o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] L_LOGIC = 8'(LAT_LOGIC);
  localparam logic [7:0] L_ARITH = 8'(LAT_ARITH);
  localparam logic [7:0] L_MUL   = 8'(LAT_MUL);
  localparam logic [7:0] L_DIV   = 8'(LAT_DIV);

  state_t           r_state;
  logic [7:0]       r_cnt;
  logic [TAG_W-1:0] r_tag;
  logic             r_flt;
  logic             r_dz;
  logic [63:0]      r_alu_a, r_alu_b;
  logic [3:0]       r_alu_op;
  logic             r_res_valid, r_res_err;
  logic [63:0]      r_res_data;
  logic [64:0]      r_res_rem;
  logic [TAG_W-1:0] r_res_tag;

  logic w_illegal;
  logic w_dz;
  logic w_flt;

  function automatic logic [7:0] lat_of(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd8, 4'd9: lat_of = L_ARITH;
      4'd2:                   lat_of = L_MUL;
      4'd3:                   lat_of = L_DIV;
      4'd4, 4'd5, 4'd6, 4'd7: lat_of = L_LOGIC;
      default:                lat_of = 8'd1;
    endcase
  endfunction

  assign w_illegal = (i_in_op > 4'd9);
`ifdef ALU_SEQ_DIV_ZERO_CHECK_EN
  assign w_dz = (i_in_op == 4'd3) && (i_in_b == 64'd0);
`else
  assign w_dz = 1'b0;
`endif
  // Faulted requests still pass through WAIT for exactly one edge so the result path stays uniform.
  assign w_flt = w_illegal | w_dz;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_tag       <= '0;
      r_flt       <= 1'b0;
      r_dz        <= 1'b0;
      r_alu_a     <= 64'd0;
      r_alu_b     <= 64'd0;
      r_alu_op    <= 4'd0;
      r_res_valid <= 1'b0;
      r_res_err   <= 1'b0;
      r_res_data  <= 64'd0;
      r_res_rem   <= 65'd0;
      r_res_tag   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_alu_a  <= i_in_a;
            r_alu_b  <= i_in_b;
            r_alu_op <= i_in_op;
            r_tag    <= i_in_tag;
            r_flt    <= w_flt;
            r_dz     <= w_dz;
            r_cnt    <= w_flt ? 8'd1 : lat_of(i_in_op);
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt <= 8'd1) begin
            r_res_valid <= 1'b1;
            r_res_err   <= r_flt;
            r_res_tag   <= r_tag;
            if (r_flt) begin
              r_res_data <= r_dz ? {64{1'b1}} : 64'd0;
              r_res_rem  <= r_dz ? {1'b0, r_alu_a} : 65'd0;
            end else begin
              r_res_data <= i_alu_out;
              r_res_rem  <= i_alu_rem;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_op    = r_alu_op;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_rem   = r_res_rem;
  assign o_res_err   = r_res_err;
  assign o_res_tag   = r_res_tag;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Request sequencer directly upstream of the ALU. It accepts one operation at a time over a valid/ready request port and drives the ALU operand and opcode inputs, holding them stable. It waits a per-opcode-class latency for the ALU's pipelined and iterative sub-blocks to settle, then captures the ALU quotient and remainder outputs into a result register. The result is presented on a valid/ready result port. It is the only block allowed to drive the ALU's `a`, `b` and `op`.

## Interface
- `TAG_W`, 4: width of the request tag echoed with the result.
- `LAT_LOGIC`, 1: ALU cycles for AND/OR/XOR/NOT; range 1..255.
- `LAT_ARITH`, 4: cycles for ADD/SUB/SHL/SHR; range 1..255.
- `LAT_MUL`, 66: cycles for MUL; range 1..255.
- `LAT_DIV`, 130: cycles for DIV; range 1..255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid & in_ready` at a rising edge.
- `in_a`, `in_b` in 64: operands.
- `in_op` in 4: ALU opcode, encoded 0=ADD 1=SUB 2=MUL 3=DIV 4=AND 5=OR 6=XOR 7=NOT 8=SHL 9=SHR.
- `in_tag` in TAG_W: request tag.
- `alu_a`, `alu_b` out 64: to ALU `a`/`b`.
- `alu_op` out 4: to ALU `op`.
- `alu_out` in 64: from ALU `out`.
- `alu_rem` in 65: from ALU `division_remainder`.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result consumed when `res_valid & res_ready` at a rising edge.
- `res_data` out 64, `res_rem` out 65, `res_err` out 1, `res_tag` out TAG_W: result fields.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, WAIT, DONE. `in_ready = (state == IDLE)`, decoded combinationally from the state register.
- **IDLE, on accept:**
  - Register `in_a`/`in_b`/`in_op` into `alu_a`/`alu_b`/`alu_op` and latch `in_tag`.
  - Load the 8-bit counter `cnt` with the latency of the op's class.
  - Go to WAIT.
- **WAIT:**
  - `cnt` decrements every edge.
  - On the edge where `cnt == 1`: capture `res_data <= alu_out`, `res_rem <= alu_rem`, `res_err <= 0`, `res_tag <= latched tag`, `res_valid <= 1`; go to DONE.
  - `alu_a`/`alu_b`/`alu_op` stay unchanged for the whole of WAIT.
- **DONE:** all `res_*` outputs are held. On result handshake, `res_valid <= 0` and the state goes to IDLE. No new request is accepted in the same cycle.
- `res_rem` is captured for every op. It is meaningful only for DIV.
- **Illegal opcode (10..15):**
  - The ALU is not waited on; `alu_*` outputs are still loaded.
  - The next edge goes directly to DONE with `res_err=1`, `res_data=0`, `res_rem=0`.
- `alu_*` outputs retain their last values in IDLE and DONE.
- **Reset (`reset == 0` at an edge), including mid-WAIT or mid-DONE:**
  - The state returns to IDLE and any in-flight operation is discarded without producing a result.
  - `alu_a=0`, `alu_b=0`, `alu_op=0`, `cnt=0`.
  - `res_valid=0`, `res_data=0`, `res_rem=0`, `res_err=0`, `res_tag=0`, `busy=0`.

## Timing
- **Latency:**
  - Accept at edge E0, then `res_valid` is high after edge E0+LAT for the op's class.
  - With LAT=1, `res_valid` rises at E0+1.
  - An illegal opcode always takes 1 cycle.
- **Throughput:** at most one operation per LAT+2 cycles when `res_ready` is held high. The cycles are LAT in WAIT, one DONE cycle, and one IDLE cycle to accept.
- `res_ready` may be high before `res_valid` rises; the handshake then completes in the first DONE cycle.
- `in_valid` may drop without being accepted. No request-side state is held outside IDLE.

## Configuration
- **`ALU_SEQ_DIV_ZERO_CHECK_EN` defined:**
  - A DIV request with `in_b == 0` is not waited on.
  - The next edge goes to DONE with `res_err=1`, `res_data=64'hFFFF_FFFF_FFFF_FFFF`, `res_rem={1'b0, a}`.
- **Undefined:** DIV by zero is issued like any other DIV and waits LAT_DIV cycles. `res_err=0` and `res_data`/`res_rem` are whatever the ALU returns.

## Test plan
The bench uses a behavioural ALU model with the same per-class latencies.
- **ADD:** `reset` low 3 cycles, then ADD a=5 b=7 tag=3 → `in_ready` low next cycle; `res_valid` rises exactly 4 edges after accept with `res_data=12`, `res_tag=3`, `res_err=0`; `alu_a`/`alu_b` stable throughout.
- **DIV with backpressure:** DIV a=100 b=7 with `res_ready` held low 10 cycles → `res_valid` at E0+130, `res_data=14`, `res_rem=2`, held until `res_ready`; returns to IDLE one edge after the handshake.
- **Back-to-back AND:** AND then XOR with `in_valid` held high, `res_ready=1` → the second accept occurs 3 edges after the first (LAT_LOGIC+2).
- **Illegal opcode:** op=4'hC → `res_valid` at E0+1, `res_err=1`, `res_data=0`.
- **Reset mid-operation:** `reset` low during cycle 30 of a MUL → on the next edge `busy=0`, `res_valid=0`, all outputs at reset values; no result is ever produced for that MUL.
- **Divide by zero:** DIV a=9 b=0 → with the macro: `res_valid` at E0+1, `res_err=1`, `res_data` all ones, `res_rem=9`. Without the macro: `res_valid` at E0+130, `res_err=0`.
